truth_table_sweeper: RTL and testbench



---
 rtl/tt_pkg.sv | 23 ++
 rtl/tt_row_counter.sv | 40 ++++
 rtl/truth_table_sweeper.sv | 144 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// -----------------------------------------------------------------------------
// tt_pkg
// Shared types and helpers for the truth_table_sweeper slice.
//   tt_state_t   : sweeper FSM state encoding (IDLE -> SWEEP -> DONE)
//   TT_N_IN_MAX  : largest supported number of function inputs
//   tt_lut_w(n)  : width of a lookup table for an n-input function (2^n)
// No ports (package).
// -----------------------------------------------------------------------------
package tt_pkg;

    typedef enum logic [1:0] {
        TT_IDLE  = 2'd0,
        TT_SWEEP = 2'd1,
        TT_DONE  = 2'd2
    } tt_state_t;

    localparam int TT_N_IN_MAX = 6;

    function automatic int tt_lut_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_row_counter.sv
// -----------------------------------------------------------------------------
// tt_row_counter
// N_IN-bit row index for the truth-table sweep. Clear has priority over
// advance. The counter never wraps on its own: the owner clears it on the
// terminal transfer.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (index -> 0)
//   i_clear   in   force index to 0 on the next edge
//   i_advance in   increment index on the next edge
//   o_idx     out  current index (N_IN bits)
//   o_last    out  index is at its terminal value 2^N_IN-1
// -----------------------------------------------------------------------------
module tt_row_counter #(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_advance,
    output logic [N_IN-1:0] o_idx,
    output logic            o_last
);

    logic [N_IN-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
        end else if (i_advance) begin
            r_idx <= r_idx + N_IN'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_last = &r_idx;

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Holds an N_IN-input Boolean function as a 2^N_IN-bit lookup table and, on
// start, streams every input combination (ascending) with its function value
// over a valid/ready interface, then pulses done for one cycle.
// Optional feature macro: TT_COUNT_EN adds the ones_cnt port and counter.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   cfg_load   in   capture cfg_lut into the LUT (IDLE only)
//   cfg_lut    in   function table, bit i = output for combination i
//   start      in   begin a sweep (IDLE only)
//   out_valid  out  current row presented
//   out_ready  in   consumer accepts the row
//   out_x      out  input combination (MSB = first input)
//   out_s      out  function value for out_x
//   busy       out  high while sweeping
//   done       out  one-cycle pulse after the last row is accepted
//   ones_cnt   out  rows transferred with out_s=1 (TT_COUNT_EN only)
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_load,
    input  logic [tt_lut_w(N_IN)-1:0] cfg_lut,
    input  logic                      start,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_IN-1:0]           out_x,
    output logic                      out_s,
    output logic                      busy,
    output logic                      done
`ifdef TT_COUNT_EN
    ,
    output logic [N_IN:0]             ones_cnt
`endif
);

    localparam int LUT_W = tt_lut_w(N_IN);

    if (N_IN < 1 || N_IN > TT_N_IN_MAX) begin : g_bad_n_in
        $error("truth_table_sweeper: N_IN out of range 1..%0d", TT_N_IN_MAX);
    end

    tt_state_t        r_state;
    logic [LUT_W-1:0] r_lut;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_start;
    logic             w_xfer;
    logic             w_clear;
    logic             w_advance;
    logic             w_last;
    logic [N_IN-1:0]  w_idx;

    assign w_start   = (r_state == TT_IDLE) && start;
    // r_valid is only ever set in SWEEP, so a transfer implies SWEEP.
    assign w_xfer    = r_valid && out_ready;
    // Clearing on the terminal transfer parks the index at 0 for DONE/IDLE.
    assign w_clear   = w_start || (w_xfer && w_last);
    assign w_advance = w_xfer && !w_last;

    tt_row_counter #(
        .N_IN (N_IN)
    ) u_row_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_idx     (w_idx),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TT_IDLE;
            r_lut   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TT_IDLE: begin
                    // A load and start on the same edge both take effect;
                    // out_s reads r_lut directly, so row 0 sees the new table.
                    if (cfg_load) begin
                        r_lut <= cfg_lut;
                    end
                    if (start) begin
                        r_state <= TT_SWEEP;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                TT_SWEEP: begin
                    if (w_xfer && w_last) begin
                        r_state <= TT_DONE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                TT_DONE: begin
                    r_state <= TT_IDLE;
                end
                default: begin
                    r_state <= TT_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_x     = w_idx;
    assign out_s     = r_lut[w_idx];

`ifdef TT_COUNT_EN
    logic [N_IN:0] r_ones;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones <= '0;
        end else if (w_start) begin
            r_ones <= '0;
        end else if (w_xfer && out_s) begin
            r_ones <= r_ones + (N_IN + 1)'(1);
        end
    end

    assign ones_cnt = r_ones;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Self-checking bench for truth_table_sweeper: a 2-input instance driven from
// a table of sweep records, plus hand-written reset and 6-input sequences.
// ones_cnt checks are present when TT_COUNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    // 2-input instance
    logic       cfg_load;
    logic [3:0] cfg_lut;
    logic       start;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_x;
    logic       out_s;
    logic       busy;
    logic       done;

    // 6-input instance
    logic        cfg_load6;
    logic [63:0] lut6;
    logic        start6;
    logic        valid6;
    logic        ready6;
    logic [5:0]  x6;
    logic        s6;
    logic        busy6;
    logic        done6;

`ifdef TT_COUNT_EN
    logic [2:0] ones;
    logic [6:0] ones6;
`endif

    int n_checks = 0;
    int n_err    = 0;

    truth_table_sweeper #(.N_IN(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_lut   (cfg_lut),
        .start     (start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_s     (out_s),
        .busy      (busy),
        .done      (done)
`ifdef TT_COUNT_EN
        ,
        .ones_cnt  (ones)
`endif
    );

    truth_table_sweeper #(.N_IN(6)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load6),
        .cfg_lut   (lut6),
        .start     (start6),
        .out_valid (valid6),
        .out_ready (ready6),
        .out_x     (x6),
        .out_s     (s6),
        .busy      (busy6),
        .done      (done6)
`ifdef TT_COUNT_EN
        ,
        .ones_cnt  (ones6)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode: 0 = load then start, 1 = load with start, 2 = start without load
    typedef struct {
        logic [3:0] lut;
        int         mode;
        logic [3:0] pat;      // out_ready per cycle, bit (cycle % 4)
        bit         inject;   // pulse cfg_load(0000)+start during the sweep
        logic [3:0] exp_s;    // expected out_s for row i in bit i
        int         exp_ones;
    } vec_t;

    task automatic run_sweep(input vec_t v, input string tag);
        int row;
        int cyc;
        if (v.mode == 0) begin
            cfg_load = 1'b1;
            cfg_lut  = v.lut;
            @(negedge clk);
            cfg_load = 1'b0;
        end
        cfg_lut  = v.lut;
        cfg_load = (v.mode == 1);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cfg_load = 1'b0;
        row = 0;
        cyc = 0;
        while (row < 4 && cyc < 40) begin
            chk({tag, " valid"}, 64'(out_valid), 64'd1);
            chk({tag, " busy"},  64'(busy),      64'd1);
            chk({tag, " done_low"}, 64'(done),   64'd0);
            chk({tag, " out_x"}, 64'(out_x),     64'(row));
            chk({tag, " out_s"}, 64'(out_s),     64'(v.exp_s[row]));
            cfg_load = 1'b0;
            start    = 1'b0;
            if (v.inject && cyc == 1) begin
                cfg_load = 1'b1;
                cfg_lut  = 4'b0000;
                start    = 1'b1;
            end
            out_ready = v.pat[cyc % 4];
            @(negedge clk);
            if (out_ready) row++;
            cyc++;
        end
        chk({tag, " rows_done_in_budget"}, 64'(row), 64'd4);
        out_ready = 1'b0;
        cfg_load  = 1'b0;
        start     = 1'b0;
        chk({tag, " done_pulse"}, 64'(done),      64'd1);
        chk({tag, " valid_off"},  64'(out_valid), 64'd0);
        chk({tag, " busy_off"},   64'(busy),      64'd0);
`ifdef TT_COUNT_EN
        chk({tag, " ones_cnt"}, 64'(ones), 64'(v.exp_ones));
`endif
        @(negedge clk);
        chk({tag, " done_single"}, 64'(done),      64'd0);
        chk({tag, " idle_valid"},  64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, " no_queued_start"}, 64'(out_valid | busy | done), 64'd0);
`ifdef TT_COUNT_EN
        chk({tag, " ones_hold"}, 64'(ones), 64'(v.exp_ones));
`endif
    endtask

    vec_t tbl[5];
    vec_t zero_v;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{lut: 4'b0010, mode: 0, pat: 4'b1111, inject: 1'b0, exp_s: 4'b0010, exp_ones: 1};
        tbl[1] = '{lut: 4'b1000, mode: 0, pat: 4'b1001, inject: 1'b0, exp_s: 4'b1000, exp_ones: 1};
        tbl[2] = '{lut: 4'b1111, mode: 1, pat: 4'b1111, inject: 1'b0, exp_s: 4'b1111, exp_ones: 4};
        tbl[3] = '{lut: 4'b0110, mode: 0, pat: 4'b1111, inject: 1'b1, exp_s: 4'b0110, exp_ones: 2};
        tbl[4] = '{lut: 4'b0101, mode: 0, pat: 4'b0011, inject: 1'b0, exp_s: 4'b0101, exp_ones: 2};
        zero_v = '{lut: 4'b1111, mode: 2, pat: 4'b1111, inject: 1'b0, exp_s: 4'b0000, exp_ones: 0};

        rst_n     = 1'b0;
        cfg_load  = 1'b0;
        cfg_lut   = '0;
        start     = 1'b0;
        out_ready = 1'b0;
        cfg_load6 = 1'b0;
        lut6      = '0;
        start6    = 1'b0;
        ready6    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst valid", 64'(out_valid), 64'd0);
        chk("rst busy",  64'(busy),      64'd0);
        chk("rst done",  64'(done),      64'd0);
        chk("rst out_x", 64'(out_x),     64'd0);
        chk("rst out_s", 64'(out_s),     64'd0);
`ifdef TT_COUNT_EN
        chk("rst ones",  64'(ones),      64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_sweep(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a sweep while row 01 is presented
        cfg_load = 1'b1;
        cfg_lut  = 4'b1101;
        @(negedge clk);
        cfg_load = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("midrst at_row1", 64'(out_x), 64'd1);
        chk("midrst busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst valid", 64'(out_valid), 64'd0);
        chk("midrst busy",  64'(busy),      64'd0);
        chk("midrst done",  64'(done),      64'd0);
        chk("midrst out_x", 64'(out_x),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst no_done", 64'(done), 64'd0);
        run_sweep(zero_v, "zero_after_rst");

        // 6-input sweep with alternating table
        cfg_load6 = 1'b1;
        lut6      = 64'hAAAA_AAAA_AAAA_AAAA;
        @(negedge clk);
        cfg_load6 = 1'b0;
        start6    = 1'b1;
        ready6    = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("n6 valid", 64'(valid6), 64'd1);
            chk("n6 out_x", 64'(x6),     64'(i));
            chk("n6 out_s", 64'(s6),     64'(i % 2));
            chk("n6 done_low", 64'(done6), 64'd0);
            @(negedge clk);
        end
        ready6 = 1'b0;
        chk("n6 done_pulse", 64'(done6),  64'd1);
        chk("n6 valid_off",  64'(valid6), 64'd0);
        chk("n6 busy_off",   64'(busy6),  64'd0);
`ifdef TT_COUNT_EN
        chk("n6 ones_cnt", 64'(ones6), 64'd32);
`endif
        @(negedge clk);
        chk("n6 done_single", 64'(done6), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
